// File: rtl/interrupt_source.sv
// CPU-side reset sequencer and NMI/IRQ generator for a 65xx-style bus on the phi2 clock.
// Sequences resb around the reset-vector fetch and shapes NMI/IRQ lines.
module interrupt_source #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned NMI_WIDTH   = 2,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic       phi2,
    input  logic       res,
    input  logic       soft_reset_req,
    input  logic       nmi_req,
    input  logic [3:0] irq_src,
    input  logic [3:0] irq_mask,
    input  logic       vpb,
    output logic       resb,
    output logic       nmib,
    output logic       irqb,
    output logic       reset_busy,
    output logic       reset_timeout,
    output logic [3:0] irq_status,
    output logic [7:0] vec_count
);

    localparam int unsigned CntMax = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned NmiW   = $clog2(NMI_WIDTH + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] ToLast   = CntW'(TIMEOUT - 1);
    localparam logic [NmiW-1:0] NmiLast  = NmiW'(NMI_WIDTH - 1);

    typedef enum logic [1:0] {
        StHold,
        StRelease,
        StVector,
        StIdle
    } rst_state_e;

    rst_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            resb_q, resb_d;
    logic            timeout_q, timeout_d;
    logic [7:0]      vec_q, vec_d;
    logic [1:0]      vpb_run_q, vpb_run_d;
    logic            vec_inc;

    logic            nmi_prev_q;
    logic            nmi_event;
    logic            nmib_q, nmib_d;
    logic            nmi_pend_q, nmi_pend_d;
    logic [NmiW-1:0] nmi_cnt_q, nmi_cnt_d;

    logic            irqb_q, irqb_d;
    logic [3:0]      irq_status_q, irq_status_d;
    logic            busy;

    assign busy = (state_q != StIdle);

    // Reset sequencer; the RELEASE counter keeps its value across a failed VECTOR attempt.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        vec_inc   = 1'b0;
        unique case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (cnt_q == ToLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!vpb) begin
                        state_d = StVector;
                    end
                end
            end
            StVector: begin
                if (!vpb) begin
                    state_d = StIdle;
                    vec_inc = 1'b1;
                end else begin
                    state_d = StRelease;
                end
            end
            StIdle: begin
                if (soft_reset_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
                if (!vpb && (vpb_run_q == 2'd1)) begin
                    vec_inc = 1'b1;
                end
            end
            default: begin
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating length of the current vpb-low run: 0 = high, 1 = one low cycle, 2 = longer.
    always_comb begin
        vpb_run_d = vpb_run_q;
        if (vpb) begin
            vpb_run_d = 2'd0;
        end else if (vpb_run_q != 2'd2) begin
            vpb_run_d = vpb_run_q + 2'd1;
        end
    end

    always_comb begin
        resb_d = (state_d != StHold);
        vec_d  = vec_inc ? (vec_q + 8'd1) : vec_q;
    end

    assign nmi_event = nmi_req & ~nmi_prev_q;

    // NMI pulse shaper: one pending event queued while low, served after one high cycle.
    always_comb begin
        nmib_d     = nmib_q;
        nmi_pend_d = nmi_pend_q;
        nmi_cnt_d  = nmi_cnt_q;
        if (busy) begin
            nmib_d     = 1'b1;
            nmi_pend_d = 1'b0;
            nmi_cnt_d  = '0;
        end else if (!nmib_q) begin
            if (nmi_event) begin
                nmi_pend_d = 1'b1;
            end
            if (nmi_cnt_q == NmiLast) begin
                nmib_d    = 1'b1;
                nmi_cnt_d = '0;
            end else begin
                nmi_cnt_d = nmi_cnt_q + 1'b1;
            end
        end else if (nmi_event || nmi_pend_q) begin
            nmib_d     = 1'b0;
            nmi_pend_d = 1'b0;
            nmi_cnt_d  = '0;
        end
    end

    always_comb begin
        irq_status_d = irq_src & irq_mask;
        irqb_d       = busy | ~(|(irq_src & irq_mask));
    end

    always_ff @(posedge phi2) begin
        if (res) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            resb_q       <= 1'b0;
            timeout_q    <= 1'b0;
            vec_q        <= 8'd0;
            vpb_run_q    <= 2'd0;
            nmi_prev_q   <= 1'b0;
            nmib_q       <= 1'b1;
            nmi_pend_q   <= 1'b0;
            nmi_cnt_q    <= '0;
            irqb_q       <= 1'b1;
            irq_status_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resb_q       <= resb_d;
            timeout_q    <= timeout_d;
            vec_q        <= vec_d;
            vpb_run_q    <= vpb_run_d;
            nmi_prev_q   <= nmi_req;
            nmib_q       <= nmib_d;
            nmi_pend_q   <= nmi_pend_d;
            nmi_cnt_q    <= nmi_cnt_d;
            irqb_q       <= irqb_d;
            irq_status_q <= irq_status_d;
        end
    end

    assign resb          = resb_q;
    assign nmib          = nmib_q;
    assign irqb          = irqb_q;
    assign reset_busy    = busy;
    assign reset_timeout = timeout_q;
    assign irq_status    = irq_status_q;
    assign vec_count     = vec_q;

endmodule

// File: tb/tb_interrupt_source.sv
// Directed bench for interrupt_source: expectations are queued with each stimulus step and
// checked against the outputs one clock later.
module tb_interrupt_source;

    localparam int SigResb    = 0;
    localparam int SigNmib    = 1;
    localparam int SigIrqb    = 2;
    localparam int SigBusy    = 3;
    localparam int SigTimeout = 4;
    localparam int SigStatus  = 5;
    localparam int SigVec     = 6;

    logic       phi2 = 1'b0;
    logic       res;
    logic       soft_reset_req;
    logic       nmi_req;
    logic [3:0] irq_src;
    logic [3:0] irq_mask;
    logic       vpb;
    logic       resb;
    logic       nmib;
    logic       irqb;
    logic       reset_busy;
    logic       reset_timeout;
    logic [3:0] irq_status;
    logic [7:0] vec_count;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    interrupt_source #(
        .HOLD_CYCLES(4),
        .NMI_WIDTH  (2),
        .TIMEOUT    (32)
    ) dut (
        .phi2          (phi2),
        .res           (res),
        .soft_reset_req(soft_reset_req),
        .nmi_req       (nmi_req),
        .irq_src       (irq_src),
        .irq_mask      (irq_mask),
        .vpb           (vpb),
        .resb          (resb),
        .nmib          (nmib),
        .irqb          (irqb),
        .reset_busy    (reset_busy),
        .reset_timeout (reset_timeout),
        .irq_status    (irq_status),
        .vec_count     (vec_count)
    );

    always #5 phi2 = ~phi2;

    function automatic logic [7:0] b(bit x);
        return x ? 8'd1 : 8'd0;
    endfunction

    function automatic logic [7:0] obs_of(int sig);
        case (sig)
            SigResb:    return b(resb);
            SigNmib:    return b(nmib);
            SigIrqb:    return b(irqb);
            SigBusy:    return b(reset_busy);
            SigTimeout: return b(reset_timeout);
            SigStatus:  return {4'd0, irq_status};
            default:    return vec_count;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sig, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    // Advance one phi2 edge, then check everything queued for it.
    task automatic tick();
        exp_t       e;
        logic [7:0] obs;
        @(posedge phi2);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = obs_of(e.sig);
            n_checks++;
            assert (obs === e.val)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    bit nmi_pat[10]  = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    bit nmib_pat[10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1};

    initial begin
        res            = 1'b1;
        soft_reset_req = 1'b0;
        nmi_req        = 1'b0;
        irq_src        = 4'hF;
        irq_mask       = 4'hF;
        vpb            = 1'b1;
        tick();

        // Reset values while res is held.
        push_exp("rst_resb", SigResb, 8'd0);
        push_exp("rst_nmib", SigNmib, 8'd1);
        push_exp("rst_irqb", SigIrqb, 8'd1);
        push_exp("rst_busy", SigBusy, 8'd1);
        push_exp("rst_timeout", SigTimeout, 8'd0);
        push_exp("rst_status", SigStatus, 8'd0);
        push_exp("rst_vec", SigVec, 8'd0);
        tick();

        // Power-on sequence, vector pull at cycles 10-11; IRQ sources active throughout.
        res = 1'b0;
        for (int k = 0; k < 12; k++) begin
            vpb = (k < 10);
            push_exp("por_resb", SigResb, b(k >= 3));
            push_exp("por_busy", SigBusy, b(k < 11));
            push_exp("por_irqb_masked", SigIrqb, 8'd1);
            if (k == 0) push_exp("por_status", SigStatus, 8'h0F);
            if (k == 11) push_exp("por_vec", SigVec, 8'd1);
            tick();
        end
        vpb = 1'b1;
        push_exp("idle_irqb_on", SigIrqb, 8'd0);
        tick();
        irq_src = 4'h0;
        push_exp("irq_clear", SigIrqb, 8'd1);
        push_exp("irq_clear_status", SigStatus, 8'd0);
        tick();

        // Masking.
        irq_mask = 4'b0100;
        irq_src  = 4'b0011;
        push_exp("mask_off_irqb", SigIrqb, 8'd1);
        push_exp("mask_off_status", SigStatus, 8'd0);
        tick();
        irq_src = 4'b0111;
        push_exp("mask_on_irqb", SigIrqb, 8'd0);
        push_exp("mask_on_status", SigStatus, 8'h04);
        tick();
        irq_src = 4'b0000;
        push_exp("mask_clr_irqb", SigIrqb, 8'd1);
        push_exp("mask_clr_status", SigStatus, 8'd0);
        tick();

        // Back-to-back NMI events: pulses 2 low / 1 high / 2 low / 1 high / 2 low.
        for (int j = 0; j < 10; j++) begin
            nmi_req = nmi_pat[j];
            push_exp($sformatf("nmi_seq%0d", j), SigNmib, b(nmib_pat[j]));
            tick();
        end
        nmi_req = 1'b0;
        push_exp("nmi_done", SigNmib, 8'd1);
        tick();

        // Soft reset; NMI edge and a second soft request during HOLD are discarded.
        soft_reset_req = 1'b1;
        push_exp("soft_resb0", SigResb, 8'd0);
        push_exp("soft_busy", SigBusy, 8'd1);
        tick();
        soft_reset_req = 1'b0;
        nmi_req        = 1'b1;
        push_exp("soft_nmib_hold", SigNmib, 8'd1);
        push_exp("soft_resb1", SigResb, 8'd0);
        tick();
        soft_reset_req = 1'b1;
        push_exp("soft_resb2", SigResb, 8'd0);
        tick();
        soft_reset_req = 1'b0;
        push_exp("soft_resb3", SigResb, 8'd0);
        tick();
        push_exp("soft_release", SigResb, 8'd1);
        push_exp("soft_busy_rel", SigBusy, 8'd1);
        tick();
        vpb = 1'b0;
        push_exp("soft_vec_busy", SigBusy, 8'd1);
        tick();
        push_exp("soft_idle", SigBusy, 8'd0);
        push_exp("soft_vec", SigVec, 8'd2);
        tick();
        vpb = 1'b1;
        for (int j = 0; j < 4; j++) begin
            push_exp("soft_no_nmi", SigNmib, 8'd1);
            tick();
        end
        nmi_req = 1'b0;

        // Vector-fetch timeout.
        res = 1'b1;
        push_exp("to_rst_vec", SigVec, 8'd0);
        push_exp("to_rst_resb", SigResb, 8'd0);
        tick();
        res = 1'b0;
        for (int k = 0; k < 36; k++) begin
            push_exp("to_resb", SigResb, b(k >= 3));
            push_exp("to_busy", SigBusy, b(k < 35));
            push_exp("to_flag", SigTimeout, b(k == 35));
            tick();
        end
        push_exp("to_sticky", SigTimeout, 8'd1);
        push_exp("to_resb_high", SigResb, 8'd1);
        tick();

        // res in the middle of an NMI pulse.
        nmi_req = 1'b1;
        push_exp("mid_nmi_low", SigNmib, 8'd0);
        tick();
        res = 1'b1;
        push_exp("mid_res_nmib", SigNmib, 8'd1);
        push_exp("mid_res_resb", SigResb, 8'd0);
        push_exp("mid_res_timeout", SigTimeout, 8'd0);
        push_exp("mid_res_busy", SigBusy, 8'd1);
        tick();

        // vec_count wrap: fast reset, then 254 IDLE pulls, then a 3-cycle pull at 255.
        res     = 1'b0;
        nmi_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vpb = (k < 4);
            if (k == 5) begin
                push_exp("wrap_boot_vec", SigVec, 8'd1);
                push_exp("wrap_boot_busy", SigBusy, 8'd0);
            end
            tick();
        end
        vpb = 1'b1;
        tick();
        for (int i = 0; i < 254; i++) begin
            vpb = 1'b0;
            tick();
            push_exp("wrap_count", SigVec, 8'(i + 2));
            tick();
            vpb = 1'b1;
            tick();
        end
        vpb = 1'b0;
        push_exp("wrap_255", SigVec, 8'd255);
        tick();
        push_exp("wrap_to_0", SigVec, 8'd0);
        tick();
        push_exp("wrap_single", SigVec, 8'd0);
        tick();
        vpb = 1'b1;
        push_exp("wrap_after", SigVec, 8'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
